// File: rtl/rgb_led_pwm_if.sv
// Handshake bundle between the general-purpose output bus and the RGB LED PWM dimmer.
// The master drives enable and channel requests; the slave returns PWM drive and the period pulse.
interface rgb_led_pwm_if #(
    parameter int unsigned NumChannels = 12
);
    logic                   en_i;
    logic [NumChannels-1:0] chan_i;
    logic [NumChannels-1:0] pwm_o;
    logic                   period_start_o;

    modport master (
        output en_i,
        output chan_i,
        input  pwm_o,
        input  period_start_o
    );

    modport slave (
        input  en_i,
        input  chan_i,
        output pwm_o,
        output period_start_o
    );
endinterface

// File: rtl/rgb_led_pwm.sv
// Multi-channel LED PWM dimmer with brightness cap; levels only change at period boundaries.
// Optional macro RGB_PWM_FADE_EN ramps levels toward their targets instead of stepping.
module rgb_led_pwm #(
    parameter int unsigned NumChannels = 12,
    parameter int unsigned CntWidth    = 8,
    parameter int unsigned PrescaleDiv = 50,
    parameter int unsigned MaxDuty     = 64,
    parameter int unsigned FadeDiv     = 4,
    parameter int unsigned FadeStep    = 1
) (
    input logic          clk_sys_i,
    input logic          rst_sys_i,
    rgb_led_pwm_if.slave bus
);
    localparam int unsigned        PsWidth = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam logic [PsWidth-1:0] PsLast  = PsWidth'(PrescaleDiv - 1);
    localparam logic [CntWidth-1:0] OnLevel = CntWidth'(MaxDuty);

    if (PrescaleDiv < 1) begin : g_bad_prescale
        $error("rgb_led_pwm: PrescaleDiv must be at least 1");
    end
    if (MaxDuty > (2 ** CntWidth) - 1) begin : g_bad_duty
        $error("rgb_led_pwm: MaxDuty must not exceed 2^CntWidth-1");
    end

    logic [PsWidth-1:0]     ps_cnt;
    logic [CntWidth-1:0]    pwm_cnt;
    logic [NumChannels-1:0] chan_q;
    logic [NumChannels-1:0] pwm_q;
    logic                   period_start_q;
    logic [CntWidth-1:0]    level [NumChannels];
    logic                   tick;
    logic                   wrap;

    assign tick = (ps_cnt == PsLast);
    assign wrap = tick && (pwm_cnt == '1);

    assign bus.pwm_o          = pwm_q;
    assign bus.period_start_o = period_start_q;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            ps_cnt         <= '0;
            pwm_cnt        <= '0;
            chan_q         <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            chan_q         <= bus.chan_i;
            ps_cnt         <= tick ? '0 : ps_cnt + 1'b1;
            period_start_q <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            for (int unsigned i = 0; i < NumChannels; i++) begin
                pwm_q[i] <= bus.en_i && (pwm_cnt < level[i]);
            end
        end
    end

`ifdef RGB_PWM_FADE_EN
    localparam int unsigned          FadeWidth = (FadeDiv > 1) ? $clog2(FadeDiv) : 1;
    localparam logic [FadeWidth-1:0] FadeLast  = FadeWidth'(FadeDiv - 1);
    localparam int unsigned          StepSat   =
        (FadeStep > (2 ** CntWidth) - 1) ? (2 ** CntWidth) - 1 : FadeStep;
    localparam logic [CntWidth-1:0]  Step      = CntWidth'(StepSat);

    if (FadeDiv < 1) begin : g_bad_fade_div
        $error("rgb_led_pwm: FadeDiv must be at least 1");
    end

    logic [FadeWidth-1:0] fade_cnt;
    logic                 fade_now;

    assign fade_now = (fade_cnt == FadeLast);

    // Saturating move toward the target; differences are taken in the right order so no wrap occurs.
    function automatic logic [CntWidth-1:0] fade_toward(input logic [CntWidth-1:0] cur,
                                                        input logic [CntWidth-1:0] tgt);
        if (cur < tgt) begin
            return ((tgt - cur) > Step) ? cur + Step : tgt;
        end else begin
            return ((cur - tgt) > Step) ? cur - Step : tgt;
        end
    endfunction

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            fade_cnt <= '0;
            for (int unsigned i = 0; i < NumChannels; i++) begin
                level[i] <= '0;
            end
        end else if (wrap) begin
            fade_cnt <= fade_now ? '0 : fade_cnt + 1'b1;
            if (fade_now) begin
                for (int unsigned i = 0; i < NumChannels; i++) begin
                    level[i] <= fade_toward(level[i], chan_q[i] ? OnLevel : '0);
                end
            end
        end
    end
`else
    // Fade parameters have no effect in this build.
    if (FadeDiv == 0 && FadeStep == 0) begin : g_fade_params_unused
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                level[i] <= '0;
            end
        end else if (wrap) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                level[i] <= chan_q[i] ? OnLevel : '0;
            end
        end
    end
`endif
endmodule
